// File: rtl/seq_mul_pkg.sv
// Shared types for the iterative shift-and-add multiplier: FSM state encoding
// and the helper that sizes the iteration counter.
package seq_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must hold 0..N, so it needs clog2(N+1) bits.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/seq_mul_addsub.sv
// Combinational W-bit adder/subtractor used by the multiplier accumulator.
// The subtract path is only exercised when SEQ_MUL_SIGNED_EN is defined.
module seq_mul_addsub #(
    parameter int W = 16
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_sub,
    output logic [W-1:0] o_sum
);

    always_comb begin
        o_sum = i_sub ? (i_a - i_b) : (i_a + i_b);
    end

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Iterative shift-and-add multiplier, one multiplier bit per clock, with
// valid/ready handshakes. Define SEQ_MUL_SIGNED_EN for two's-complement operands.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; the producer holds data stable while valid is high and not yet accepted.
module seq_shift_add_multiplier
    import seq_mul_pkg::*;
#(
    parameter int M = 8,
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [M-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [M+N-1:0] product,
    output logic           busy,
    output state_t         dbg_state
);

    localparam int W  = M + N;
    localparam int CW = cnt_w(N);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [W-1:0]   r_a_ext;
    logic [N-1:0]   r_b;
    logic [W-1:0]   r_acc;
    logic [W-1:0]   r_product;
    logic [CW-1:0]  r_count;

    logic           w_accept;
    logic           w_last;
    logic [N-1:0]   w_b_shift;
    logic           w_cur_bit;
    logic [W-1:0]   w_addend;
    logic [W-1:0]   w_sum;
    logic           w_sub;
    logic [W-1:0]   w_acc_nxt;
    logic [W-1:0]   w_a_ext_in;

    assign w_accept  = (r_state == IDLE) && in_valid;
    assign w_last    = (r_count == CW'(N - 1));
    assign w_b_shift = r_b >> r_count;
    assign w_cur_bit = w_b_shift[0];
    assign w_addend  = r_a_ext << r_count;

`ifdef SEQ_MUL_SIGNED_EN
    // The MSB of a two's-complement multiplier carries negative weight.
    assign w_a_ext_in = {{N{a[M-1]}}, a};
    assign w_sub      = w_last && w_cur_bit;
`else
    assign w_a_ext_in = {{N{1'b0}}, a};
    assign w_sub      = 1'b0;
`endif

    seq_mul_addsub #(.W(W)) u_addsub (
        .i_a   (r_acc),
        .i_b   (w_addend),
        .i_sub (w_sub),
        .o_sum (w_sum)
    );

    assign w_acc_nxt = w_cur_bit ? w_sum : r_acc;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_state_nxt = RUN;
            RUN:     if (w_last)    w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default:                w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_ext   <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_product <= '0;
            r_count   <= '0;
        end else if (w_accept) begin
            r_a_ext <= w_a_ext_in;
            r_b     <= b;
            r_acc   <= '0;
            r_count <= '0;
        end else if (r_state == RUN) begin
            r_acc   <= w_acc_nxt;
            r_count <= r_count + 1'b1;
            if (w_last) begin
                r_product <= w_acc_nxt;
            end
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign product   = r_product;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Directed bench for seq_shift_add_multiplier (M=N=8); expectations follow
// the signed encoding when SEQ_MUL_SIGNED_EN is defined.
module tb_seq_shift_add_multiplier;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [7:0]           a;
    logic [7:0]           b;
    logic                 out_valid;
    logic                 out_ready;
    logic [15:0]          product;
    logic                 busy;
    seq_mul_pkg::state_t  dbg_state;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    logic [15:0] exp_q[$];

    seq_shift_add_multiplier #(.M(8), .N(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [7:0] x, input logic [7:0] y);
`ifdef SEQ_MUL_SIGNED_EN
        logic signed [15:0] sx;
        logic signed [15:0] sy;
        sx = {{8{x[7]}}, x};
        sy = {{8{y[7]}}, y};
        return 16'(sx * sy);
`else
        return 16'({8'b0, x} * {8'b0, y});
`endif
    endfunction

    // Present operands until accepted; returns the accept-cycle label.
    task automatic issue(input logic [7:0] ia, input logic [7:0] ib,
                         input logic [15:0] exp, output int acc_cyc);
        int n;
        in_valid = 1'b1;
        a = ia;
        b = ib;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) check("issue_timeout", 32'(in_ready), 32'd1);
        exp_q.push_back(exp);
        tick();
        acc_cyc  = cyc - 1;
        in_valid = 1'b0;
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
    endtask

    // Wait for the result with out_ready high, score it, step into IDLE.
    task automatic collect(input int acc_cyc);
        int n;
        logic [15:0] exp;
        out_ready = 1'b1;
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        check("out_valid_timeout", 32'(out_valid), 32'd1);
        check("latency", 32'(cyc - acc_cyc), 32'd9);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        check("product", 32'(product), 32'(exp));
        check("in_ready_in_done", 32'(in_ready), 32'd0);
        tick();
        check("in_ready_after_done", 32'(in_ready), 32'd1);
        check("out_valid_after_done", 32'(out_valid), 32'd0);
    endtask

    initial begin
        int ac;
        int prev_ac;
        int n;
        logic [7:0] ra;
        logic [7:0] rb;
        logic [15:0] hold;

        // reset: in_valid high must not be accepted
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        a         = 8'd5;
        b         = 8'd5;
        out_ready = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_product", 32'(product), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        tick();
        tick();
        check("rst_no_accept", 32'(busy), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(seq_mul_pkg::IDLE));
        in_valid = 1'b0;
        rst_n    = 1'b1;
        tick();

        // directed products
        issue(8'd13, 8'd11, 16'h008F, ac);
        collect(ac);
`ifdef SEQ_MUL_SIGNED_EN
        issue(8'hFF, 8'hFF, 16'h0001, ac);
        collect(ac);
        issue(8'hFD, 8'd5, 16'hFFF1, ac);
        collect(ac);
        issue(8'h80, 8'h80, 16'h4000, ac);
        collect(ac);
        issue(8'h7F, 8'h80, 16'hC080, ac);
        collect(ac);
`else
        issue(8'hFF, 8'hFF, 16'hFE01, ac);
        collect(ac);
        issue(8'hFD, 8'd5, 16'h04F1, ac);
        collect(ac);
        issue(8'h80, 8'h80, 16'h4000, ac);
        collect(ac);
`endif
        issue(8'hAB, 8'h00, 16'h0000, ac);
        collect(ac);

        // backpressure: 0x21*3 = 0x63 held while a second op waits
        out_ready = 1'b0;
        issue(8'h21, 8'h03, 16'h0063, ac);
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        check("bp_latency", 32'(cyc - ac), 32'd9);
        in_valid = 1'b1;
        a = 8'd7;
        b = 8'd9;
        for (int i = 0; i < 5; i++) begin
            check("bp_product", 32'(product), 32'h63);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        hold = exp_q.pop_front();
        check("bp_product_release", 32'(product), 32'(hold));
        out_ready = 1'b1;
        tick();
        check("bp_idle_in_ready", 32'(in_ready), 32'd1);
        check("bp_not_yet_accepted", 32'(busy), 32'd0);
        check("bp_product_kept", 32'(product), 32'h63);
        exp_q.push_back(16'h003F);
        tick();
        check("bp_second_accepted", 32'(busy), 32'd1);
        ac = cyc - 1;
        in_valid = 1'b0;
        collect(ac);

        // reset in the 4th RUN cycle
        issue(8'h55, 8'hFF, model(8'h55, 8'hFF), ac);
        void'(exp_q.pop_front());
        tick();
        tick();
        tick();
        check("midop_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midop_out_valid", 32'(out_valid), 32'd0);
        check("midop_product", 32'(product), 32'd0);
        check("midop_busy", 32'(busy), 32'd0);
        #2;
        rst_n = 1'b1;
        tick();
        check("midop_idle", 32'(dbg_state), 32'(seq_mul_pkg::IDLE));
        issue(8'd2, 8'd3, 16'h0006, ac);
        collect(ac);

        // back-to-back random pairs
        prev_ac = 0;
        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            issue(ra, rb, model(ra, rb), ac);
            if (i > 0) check("issue_interval", 32'(ac - prev_ac), 32'd10);
            prev_ac = ac;
            collect(ac);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_shift_add_multiplier.md
# seq_shift_add_multiplier

Iterative shift-and-add multiplier with parametrised operand widths and valid/ready handshakes on both sides. It retires one multiplier bit per clock. Full-width operands are captured, and a registered full-width product is delivered. It sits in the arithmetic datapath as a small-area multiplier for throughput-tolerant consumers; the upstream source and downstream sink are decoupled by the handshakes.

## Interface
- M, 8, multiplicand (a) width, ≥2
- N, 8, multiplier (b) width, ≥2; sets iteration count
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operands present
- in_ready  out  1  block can accept operands; equals (state==IDLE)
- a  in  M  multiplicand
- b  in  N  multiplier
- out_valid  out  1  product valid; high only in DONE
- out_ready  in  1  sink accepts product
- product  out  M+N  result register
- busy  out  1  high in RUN or DONE

## Operation
- Reset state: state=IDLE, accumulator=0, product=0, out_valid=0, busy=0, count=0. in_ready reads 1 while in reset, but no transfer is accepted while rst_n=0.
- States and transitions:
  - IDLE: on in_valid&&in_ready, capture a into a_ext (M+N wide, zero-extended), capture b into b_reg, clear acc, count=0, go to RUN.
  - RUN: each cycle k=count (0..N-1), if b_reg[k]=1 then acc += a_ext<<k, otherwise acc unchanged; count++. On k=N-1, write the final sum into product and go to DONE.
  - DONE: out_valid=1, product stable. On out_ready=1, go to IDLE.
- All arithmetic is modulo 2^(M+N); the product never overflows in unsigned mode.
- in_valid is ignored outside IDLE. a and b are sampled only at acceptance and may change afterwards.
- b=0 still takes the full N RUN cycles. There is no early termination.
- product holds its last result after leaving DONE until the next result is written. It is cleared only by reset.
- Reset mid-operation: everything returns to reset values asynchronously, and the partial result is discarded.

## Timing
- Accept in cycle t. RUN occupies cycles t+1..t+N. out_valid rises in cycle t+N+1.
- If out_ready=1 in cycle t+N+1: IDLE in cycle t+N+2, with in_ready=1 that cycle. Minimum issue interval is N+2 cycles.
- out_ready low holds DONE indefinitely. product and out_valid stay stable, and in_ready stays 0.
- in_ready is never asserted in the same cycle as out_valid. There is no overlap of ops.

## Configuration
- SEQ_MUL_SIGNED_EN defined: a and b are two's complement.
  - a_ext is sign-extended.
  - On the last iteration (k=N-1), if b_reg[N-1]=1 then acc -= a_ext<<(N-1).
  - product is the two's-complement product, M+N bits.
- SEQ_MUL_SIGNED_EN undefined: unsigned only, with no subtract path. Ports and latency are identical in both builds.

## Structure
- Package seq_mul_pkg: state enum (IDLE, RUN, DONE), and a count-width constant function $clog2(N+1) exposed for M/N users.
- One sub-module, seq_mul_addsub: an (M+N)-wide combinational adder/subtractor with a sub control. Without the macro, sub is tied 0.
- Top level holds the FSM, counter, a_ext/b_reg/acc/product registers and the handshake logic.

## Test plan
- Unsigned, M=N=8: a=13, b=11 -> product=143 (0x008F). out_valid rises exactly 9 cycles after the accept cycle.
- Unsigned: a=255, b=255 -> 0xFE01. a=0xFD, b=5 -> 0x04F1. b=0 -> 0x0000 with the same 9-cycle latency.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid, and drive in_valid=1 with new operands. Required: product is held, in_ready=0, and the second op is not accepted until the cycle after out_ready=1.
- Reset mid-op: assert rst_n=0 in the 4th RUN cycle. Required: out_valid=0, product=0, busy=0 immediately. After release, a=2, b=3 -> 6.
- Signed build (SEQ_MUL_SIGNED_EN): a=0xFD (−3), b=5 -> 0xFFF1. a=0x80, b=0x80 -> 0x4000. a=0x7F, b=0x80 -> 0xC080.
- Back-to-back: 20 random pairs with out_ready=1 always. Required: issue interval is exactly 10 cycles and every product matches the reference model.
